// File: rtl/code_patch_pkg.sv
// Shared sizing and types for the code-patch transmit path.
package code_patch_pkg;

  localparam int CP_NUM_ENTRIES = 3;
  localparam int CP_ENTRY_W     = 22;
  localparam int CP_IDX_W       = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } cp_tx_state_e;

  typedef logic [CP_ENTRY_W-1:0] cp_entry_t;

endpackage

// File: rtl/code_patch_stream_tx_if.sv
// Config load port, control pulses and patch-core stream channel of the transmitter.
interface code_patch_stream_tx_if
  import code_patch_pkg::*;
#(
  parameter int IDX_W   = CP_IDX_W,
  parameter int ENTRY_W = CP_ENTRY_W
);

  logic               load_valid_i;
  logic               load_ready_o;
  logic [IDX_W-1:0]   load_idx_i;
  logic [ENTRY_W-1:0] load_data_i;
  logic               commit_i;
  logic               clear_i;
  logic               pg_valid_o;
  logic               pg_ready_i;
  logic [IDX_W-1:0]   pg_idx_o;
  logic [ENTRY_W-1:0] pg_data_o;
  logic               pg_last_o;
  logic               si_read_o;
  logic               cfg_pat_gen_o;
  logic               busy_o;
  logic               err_o;

  modport master (
    input  load_valid_i, load_idx_i, load_data_i, commit_i, clear_i, pg_ready_i,
    output load_ready_o, pg_valid_o, pg_idx_o, pg_data_o, pg_last_o,
           si_read_o, cfg_pat_gen_o, busy_o, err_o
  );

  modport slave (
    output load_valid_i, load_idx_i, load_data_i, commit_i, clear_i, pg_ready_i,
    input  load_ready_o, pg_valid_o, pg_idx_o, pg_data_o, pg_last_o,
           si_read_o, cfg_pat_gen_o, busy_o, err_o
  );

endinterface

// File: rtl/code_patch_next_sel.sv
// Finds the lowest set slot at or above start_i and flags whether it is the highest set slot.
module code_patch_next_sel
  import code_patch_pkg::*;
#(
  parameter int NUM_ENTRIES = CP_NUM_ENTRIES,
  parameter int IDX_W       = CP_IDX_W
) (
  input  logic [NUM_ENTRIES-1:0] mask_i,
  input  logic [IDX_W-1:0]       start_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   found_o,
  output logic                   last_o
);

  logic hit;

  always_comb begin
    idx_o   = {IDX_W{1'b0}};
    found_o = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit     = !found_o && mask_i[i] && (IDX_W'(i) >= start_i);
      idx_o   = hit ? IDX_W'(i) : idx_o;
      found_o = found_o | hit;
    end
    last_o = found_o;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      last_o = last_o & ~(mask_i[i] & (IDX_W'(i) > idx_o));
    end
  end

endmodule

// File: rtl/code_patch_stream_tx.sv
// Patch-table transmitter: stores config-written entries and streams the valid ones
// to the code-patch core on commit, then enables patch generation.
module code_patch_stream_tx
  import code_patch_pkg::*;
#(
  parameter int NUM_ENTRIES = CP_NUM_ENTRIES,
  parameter int ENTRY_W     = CP_ENTRY_W,
  parameter int IDX_W       = CP_IDX_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  code_patch_stream_tx_if.master bus
);

  cp_tx_state_e           state_q, state_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRY_W-1:0]     table_q [NUM_ENTRIES];
  logic [ENTRY_W-1:0]     table_d [NUM_ENTRIES];
  logic                   pg_valid_q, pg_valid_d, pg_last_q, pg_last_d;
  logic                   si_read_q, si_read_d, err_q, err_d;
  logic [IDX_W-1:0]       pg_idx_q, pg_idx_d;
  logic [ENTRY_W-1:0]     pg_data_q, pg_data_d;

  logic                   load_fire, idx_ok, wr_en, bad_load, advance, finish;
  logic [NUM_ENTRIES-1:0] wr_mask, first_mask;
  logic [IDX_W-1:0]       first_idx, next_idx, next_start;
  logic                   first_found, first_last, next_found, next_last;

  assign load_fire  = bus.load_valid_i && (state_q != STREAM);
  assign idx_ok     = (int'(bus.load_idx_i) < NUM_ENTRIES);
  assign wr_en      = load_fire && idx_ok;
  assign bad_load   = load_fire && !idx_ok;
  // The same-cycle write is folded in so a load+commit streams the new slot.
  assign wr_mask    = wr_en ? (NUM_ENTRIES'(1'b1) << bus.load_idx_i) : {NUM_ENTRIES{1'b0}};
  assign first_mask = valid_q | wr_mask;
  assign next_start = pg_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
  assign advance    = pg_valid_q && bus.pg_ready_i;
  assign finish     = advance && (pg_last_q || !next_found);

  code_patch_next_sel #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_first_sel (
    .mask_i (first_mask),
    .start_i({IDX_W{1'b0}}),
    .idx_o  (first_idx),
    .found_o(first_found),
    .last_o (first_last)
  );

  code_patch_next_sel #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_next_sel (
    .mask_i (valid_q),
    .start_i(next_start),
    .idx_o  (next_idx),
    .found_o(next_found),
    .last_o (next_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      valid_q    <= {NUM_ENTRIES{1'b0}};
      pg_valid_q <= 1'b0;
      pg_idx_q   <= {IDX_W{1'b0}};
      pg_data_q  <= {ENTRY_W{1'b0}};
      pg_last_q  <= 1'b0;
      si_read_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pg_valid_q <= pg_valid_d;
      pg_idx_q   <= pg_idx_d;
      pg_data_q  <= pg_data_d;
      pg_last_q  <= pg_last_d;
      si_read_q  <= si_read_d;
      err_q      <= err_d;
    end
  end

  // Table contents are deliberately left unreset; the valid mask alone governs them.
  always_ff @(posedge clk_i) begin
    table_q <= table_d;
  end

  always_comb begin
    valid_d = bus.clear_i ? {NUM_ENTRIES{1'b0}} : first_mask;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      table_d[i] = (wr_en && (int'(bus.load_idx_i) == i)) ? bus.load_data_i : table_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.clear_i)       state_d = IDLE;
        else if (bus.commit_i) state_d = first_found ? STREAM : IDLE;
        else if (load_fire)    state_d = IDLE;
        else                   state_d = state_q;
      end
      STREAM: begin
        if (bus.clear_i) state_d = IDLE;
        else if (finish) state_d = DONE;
        else             state_d = STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pg_valid_d = pg_valid_q;
    pg_idx_d   = pg_idx_q;
    pg_data_d  = pg_data_q;
    pg_last_d  = pg_last_q;
    si_read_d  = 1'b0;
    err_d      = bad_load;
    case (state_q)
      IDLE, DONE: begin
        if (!bus.clear_i && bus.commit_i && first_found) begin
          pg_valid_d = 1'b1;
          pg_idx_d   = first_idx;
          pg_data_d  = (wr_en && (bus.load_idx_i == first_idx)) ? bus.load_data_i
                                                                 : table_q[first_idx];
          pg_last_d  = first_last;
          si_read_d  = 1'b1;
        end else if (!bus.clear_i && bus.commit_i) begin
          pg_valid_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          pg_valid_d = 1'b0;
        end
      end
      STREAM: begin
        if (bus.clear_i) begin
          pg_valid_d = 1'b0;
          pg_last_d  = 1'b0;
        end else if (finish) begin
          pg_valid_d = 1'b0;
          pg_last_d  = 1'b0;
          err_d      = bus.commit_i;
        end else if (advance) begin
          pg_idx_d   = next_idx;
          pg_data_d  = table_q[next_idx];
          pg_last_d  = next_last;
          err_d      = bus.commit_i;
        end else begin
          err_d      = bus.commit_i;
        end
      end
      default: begin
        pg_valid_d = 1'b0;
        pg_last_d  = 1'b0;
      end
    endcase
  end

  assign bus.load_ready_o  = (state_q != STREAM);
  assign bus.pg_valid_o    = pg_valid_q;
  assign bus.pg_idx_o      = pg_idx_q;
  assign bus.pg_data_o     = pg_data_q;
  assign bus.pg_last_o     = pg_last_q;
  assign bus.si_read_o     = si_read_q;
  assign bus.cfg_pat_gen_o = (state_q == DONE);
  assign bus.busy_o        = (state_q == STREAM);
  assign bus.err_o         = err_q;

endmodule
